// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register: MSB-first frame with valid/last strobes.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // Ready is a function of state only so the producer never sees a loop through load_valid.
  assign load_ready = !reset && ((state_q == IDLE) || (state_q == SHIFT && last_q));
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0 && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (accept) begin
      sreg_d = din;
      cnt_d  = CNT_W'(FRAME - 1);
    end else if (state_q == SHIFT) begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

`ifdef PISO_PARITY_EN
  assign par_d = accept ? ^din : par_q;
`endif

  // Outputs are precomputed from next-state values so they leave the block straight from flops.
  always_comb begin
    valid_d = (state_d == SHIFT);
    last_d  = valid_d && (cnt_d == '0);
    dout_d  = valid_d ? sreg_d[WIDTH-1] : 1'b0;
`ifdef PISO_PARITY_EN
    if (last_d) dout_d = par_d;
`endif
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign busy       = valid_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg (WIDTH=4): reset, single word, streaming,
// backpressure, mid-frame reset, and parity frames when PISO_PARITY_EN is defined.
module tb_piso_shift_reg;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       load_valid;
  logic       load_ready, dout, dout_valid, dout_last, busy;
  logic [3:0] rx;
  logic [7:0] exp_bits, exp_last;
  int checks = 0;
  int errors = 0;

  piso_shift_reg #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_last(dout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic b, input logic last);
    chk({tag, " dout"}, 32'(dout), 32'(b));
    chk({tag, " valid"}, 32'(dout_valid), 32'd1);
    chk({tag, " last"}, 32'(dout_last), 32'(last));
    chk({tag, " busy"}, 32'(busy), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " dout"}, 32'(dout), 32'd0);
    chk({tag, " valid"}, 32'(dout_valid), 32'd0);
    chk({tag, " last"}, 32'(dout_last), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset held with a pending load: nothing may be accepted
    reset = 1'b1; load_valid = 1'b1; din = 4'b1111; rx = '0;
    #1;
    chk_idle("reset0");
    chk("reset0 ready", 32'(load_ready), 32'd0);
    step;
    chk_idle("reset1");
    chk("reset1 ready", 32'(load_ready), 32'd0);
    step;
    chk_idle("reset2");
    reset = 1'b0; load_valid = 1'b0;
    #1;
    chk("post-reset ready", 32'(load_ready), 32'd1);
    chk_idle("post-reset");
    $display("txn reset: done");

    // Single word 1011
    din = 4'b1011; load_valid = 1'b1;
    step;
    load_valid = 1'b0; din = 4'b0000;
    chk_bit("single b1", 1'b1, 1'b0); rx = {rx[2:0], dout};
    chk("single b1 ready", 32'(load_ready), 32'd0);
    step; chk_bit("single b2", 1'b0, 1'b0); rx = {rx[2:0], dout};
    step; chk_bit("single b3", 1'b1, 1'b0); rx = {rx[2:0], dout};
    step; chk_bit("single b4", 1'b1, 1'b1); rx = {rx[2:0], dout};
    chk("single last ready", 32'(load_ready), 32'd1);
    step;
    chk_idle("single idle");
    chk("single rx", 32'(rx), 32'hB);
    $display("txn single: rx=%b", rx);

    // Back-to-back 1100 then 0101, second accepted on the last cycle
    exp_bits = 8'b1100_0101;
    exp_last = 8'b0001_0001;
    din = 4'b1100; load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step;
      if (i == 0) din = 4'b0101;
      if (i == 4) load_valid = 1'b0;
      chk_bit($sformatf("b2b bit%0d", i + 1), exp_bits[7 - i], exp_last[7 - i]);
      if (i == 1) chk("b2b mid ready", 32'(load_ready), 32'd0);
      if (i == 3) chk("b2b last ready", 32'(load_ready), 32'd1);
    end
    step;
    chk_idle("b2b idle");
    $display("txn back-to-back: 8 bits streamed");

    // Backpressure: 1111 offered during bit 2 of frame 0110
    din = 4'b0110; load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    chk_bit("bp f1 b1", 1'b0, 1'b0);
    step;
    din = 4'b1111; load_valid = 1'b1;
    chk_bit("bp f1 b2", 1'b1, 1'b0);
    chk("bp b2 ready", 32'(load_ready), 32'd0);
    step;
    chk_bit("bp f1 b3", 1'b1, 1'b0);
    chk("bp b3 ready", 32'(load_ready), 32'd0);
    step;
    chk_bit("bp f1 b4", 1'b0, 1'b1);
    chk("bp b4 ready", 32'(load_ready), 32'd1);
    step;
    load_valid = 1'b0; din = 4'b0000;
    chk_bit("bp f2 b1", 1'b1, 1'b0);
    step; chk_bit("bp f2 b2", 1'b1, 1'b0);
    step; chk_bit("bp f2 b3", 1'b1, 1'b0);
    step; chk_bit("bp f2 b4", 1'b1, 1'b1);
    step;
    chk_idle("bp idle");
    $display("txn backpressure: held word delivered");

    // Reset pulse after bit 2 of frame 1010
    din = 4'b1010; load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    chk_bit("rst f b1", 1'b1, 1'b0);
    step;
    chk_bit("rst f b2", 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk_idle("rst abort");
    chk("rst abort ready", 32'(load_ready), 32'd0);
    step;
    chk_idle("rst held");
    reset = 1'b0;
    #1;
    din = 4'b1001; load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    chk_bit("rst new b1", 1'b1, 1'b0);
    step; chk_bit("rst new b2", 1'b0, 1'b0);
    step; chk_bit("rst new b3", 1'b0, 1'b0);
    step; chk_bit("rst new b4", 1'b1, 1'b1);
    step;
    chk_idle("rst new idle");
    $display("txn reset mid-frame: clean frame after release");

`ifdef PISO_PARITY_EN
    // Parity frames: 1011 -> parity 1, 1001 -> parity 0
    din = 4'b1011; load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    chk_bit("par1 b1", 1'b1, 1'b0);
    step; chk_bit("par1 b2", 1'b0, 1'b0);
    step; chk_bit("par1 b3", 1'b1, 1'b0);
    step; chk_bit("par1 b4", 1'b1, 1'b0);
    step; chk_bit("par1 p", 1'b1, 1'b1);
    step; chk_idle("par1 idle");
    $display("txn parity 1011: done");
    din = 4'b1001; load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    chk_bit("par2 b1", 1'b1, 1'b0);
    step; chk_bit("par2 b2", 1'b0, 1'b0);
    step; chk_bit("par2 b3", 1'b0, 1'b0);
    step; chk_bit("par2 b4", 1'b1, 1'b0);
    step; chk_bit("par2 p", 1'b0, 1'b1);
    step; chk_idle("par2 idle");
    $display("txn parity 1001: done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
